// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Core-wide constants for the RV32I instruction memory and the state
// encoding of the boot/program loader.
// No ports (package).
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int IMEM_ADDR_WIDTH = 10;
    localparam int IMEM_DATA_WIDTH = 32;
    localparam int IMEM_DEPTH      = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_FINISH = 3'd5
    } loader_state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// ---------------------------------------------------------------------------
// imem_word_assembler
// Collects little-endian bytes into one instruction word. Each accepted
// byte is shifted in from the top, so after a full word the first byte
// sits in bits 7:0.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   restart the byte count (word register is kept)
//   byte_in    in   8-bit data byte
//   byte_en    in   byte_in is accepted this cycle
//   word       out  assembled word register
//   word_valid out  high in the cycle the last byte of a word is accepted
// ---------------------------------------------------------------------------
module imem_word_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = IMEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [7:0]            byte_in,
    input  logic                  byte_en,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid
);

    localparam logic [1:0] LAST_BYTE = 2'(DATA_WIDTH / 8 - 1);

    logic [1:0] byte_cnt;

    // Strobe is combinational so the FSM can leave DATA on the same edge
    // that stores the final byte; the word is complete in the next cycle.
    assign word_valid = byte_en && (byte_cnt == LAST_BYTE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
            word     <= '0;
        end else begin
            if (byte_en) begin
                word <= {byte_in, word[DATA_WIDTH-1:8]};
            end
            if (clear) begin
                byte_cnt <= 2'd0;
            end else if (byte_en) begin
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot loader and address arbiter for the instruction memory. A load is a
// 16-bit little-endian word count N followed by 4*N little-endian data
// bytes; words are written to addresses 0..N-1. The CPU is held for the
// whole load; in IDLE the CPU fetch address drives the memory directly.
// Ports:
//   CLK          in   clock, rising edge
//   RESET_N      in   asynchronous active-low reset
//   START        in   one-cycle load request (ignored while busy)
//   ABORT        in   abandon an in-progress load
//   RX_DATA      in   byte from UART receiver
//   RX_VALID     in   RX_DATA valid
//   RX_READY     out  byte accepted when RX_VALID is also high
//   CPU_ADDRESS  in   fetch word address from the PC
//   MEM_ADDRESS  out  instruction memory address
//   MEM_WDATA    out  instruction memory write data
//   MEM_WE       out  write enable, one cycle per word
//   CPU_HOLD     out  stall the core
//   BUSY         out  not idle
//   DONE         out  one-cycle pulse at the end of a load
//   ERROR        out  sticky load error (oversize length or abort)
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = IMEM_DATA_WIDTH,
    parameter int MAX_WORDS  = IMEM_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [7:0]            RX_DATA,
    input  logic                  RX_VALID,
    output logic                  RX_READY,
    input  logic [ADDR_WIDTH-1:0] CPU_ADDRESS,
    output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    output logic                  MEM_WE,
    output logic                  CPU_HOLD,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    loader_state_t         state;
    logic [15:0]           len_reg;
    logic [ADDR_WIDTH-1:0] word_ptr;
    logic                  error_reg;

    logic                  byte_take;
    logic [15:0]           len_next;
    logic                  last_word;
    logic                  asm_clear;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] asm_word;

    // ABORT wins over any byte transfer in the same cycle, so a byte offered
    // alongside ABORT is never consumed.
    assign byte_take = RX_VALID && RX_READY && !ABORT;
    assign len_next  = {RX_DATA, len_reg[7:0]};

    // Termination compares against N-1 before incrementing, so N equal to
    // the memory depth finishes at the top address without wrapping.
    assign last_word = (16'(word_ptr) == (len_reg - 16'd1));

    assign asm_clear = ((state == ST_IDLE) && START) ||
                       ((state == ST_WRITE) && !ABORT);

    imem_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_assembler (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .clear      (asm_clear),
        .byte_in    (RX_DATA),
        .byte_en    (byte_take && (state == ST_DATA)),
        .word       (asm_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            len_reg   <= 16'd0;
            word_ptr  <= '0;
            error_reg <= 1'b0;
        end else if (ABORT && (state != ST_IDLE)) begin
            state     <= ST_IDLE;
            error_reg <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state     <= ST_LEN_LO;
                        error_reg <= 1'b0;
                        word_ptr  <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (byte_take) begin
                        len_reg <= {8'h00, RX_DATA};
                        state   <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (byte_take) begin
                        len_reg <= len_next;
                        if (len_next == 16'd0) begin
                            state <= ST_FINISH;
                        end else if (len_next > MAX_LEN) begin
                            state     <= ST_FINISH;
                            error_reg <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_valid) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (last_word) begin
                        state <= ST_FINISH;
                    end else begin
                        word_ptr <= word_ptr + 1'b1;
                        state    <= ST_DATA;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs are decoded from registered state; only the IDLE address
    // path is a combinational passthrough of the CPU fetch address.
    assign RX_READY    = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                         (state == ST_DATA);
    assign MEM_WE      = (state == ST_WRITE);
    assign MEM_WDATA   = asm_word;
    assign MEM_ADDRESS = (state == ST_IDLE) ? CPU_ADDRESS : word_ptr;
    assign CPU_HOLD    = (state != ST_IDLE);
    assign BUSY        = (state != ST_IDLE);
    assign DONE        = (state == ST_FINISH);
    assign ERROR       = error_reg;

endmodule
